// File: rtl/change_dispenser_if.sv
`default_nettype none
// change_dispenser_if -- request/status bundle between a payout client and change_dispenser
// Rev 1.0
interface change_dispenser_if #(
  parameter int AMT_W = 16,
  parameter int INV_W = 8
);
  logic                    in_start;
  logic signed [AMT_W-1:0] in_amount;
  logic                    in_refill;
  logic                    out_busy;
  logic                    out_coin_1;
  logic                    out_coin_05;
  logic                    out_coin_025;
  logic                    out_done;
  logic                    out_short;
  logic                    out_err;
  logic [AMT_W-2:0]        out_remain;
  logic [INV_W-1:0]        out_inv_1;
  logic [INV_W-1:0]        out_inv_05;
  logic [INV_W-1:0]        out_inv_025;
  logic [1:0]              out_state;

  modport slave (
    input  in_start, in_amount, in_refill,
    output out_busy, out_coin_1, out_coin_05, out_coin_025, out_done,
           out_short, out_err, out_remain, out_inv_1, out_inv_05,
           out_inv_025, out_state
  );

  modport master (
    output in_start, in_amount, in_refill,
    input  out_busy, out_coin_1, out_coin_05, out_coin_025, out_done,
           out_short, out_err, out_remain, out_inv_1, out_inv_05,
           out_inv_025, out_state
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// change_dispenser -- pays signed change in quarters as $1/$0.50/$0.25 pulses with inventory fallback
// Rev 1.0
module change_dispenser #(
  parameter int AMT_W        = 16,
  parameter int INV_W        = 8,
  parameter int INV_1_INIT   = 20,
  parameter int INV_05_INIT  = 20,
  parameter int INV_025_INIT = 40,
  parameter int GAP          = 1
) (
  input  logic              in_clka,
  input  logic              in_restart,
  change_dispenser_if.slave bus
);

  localparam int RW    = AMT_W - 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_PAY  = 2'd1;
  localparam logic [1:0] c_ST_GAP  = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);
  localparam logic [INV_W-1:0] c_INV_1    = INV_W'(INV_1_INIT);
  localparam logic [INV_W-1:0] c_INV_05   = INV_W'(INV_05_INIT);
  localparam logic [INV_W-1:0] c_INV_025  = INV_W'(INV_025_INIT);
  localparam logic [INV_W-1:0] c_INV_DEC  = INV_W'(1);
  localparam logic [RW-1:0]    c_Q1       = RW'(1);
  localparam logic [RW-1:0]    c_Q2       = RW'(2);
  localparam logic [RW-1:0]    c_Q4       = RW'(4);

  logic [1:0]       r_state;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [RW-1:0]    r_remain;
  logic [INV_W-1:0] r_inv_1;
  logic [INV_W-1:0] r_inv_05;
  logic [INV_W-1:0] r_inv_025;
  logic             r_coin_1;
  logic             r_coin_05;
  logic             r_coin_025;
  logic             r_done;
  logic             r_short;
  logic             r_err;

  logic [2:0]       w_coin;
  logic [RW-1:0]    w_rem_next;

  // Largest coin that fits the remainder and is still stocked; 3'b000 means shortfall.
  always_comb begin
    w_coin     = 3'b000;
    w_rem_next = r_remain;
    if (r_remain >= c_Q4 && r_inv_1 != '0) begin
      w_coin     = 3'b100;
      w_rem_next = r_remain - c_Q4;
    end else if (r_remain >= c_Q2 && r_inv_05 != '0) begin
      w_coin     = 3'b010;
      w_rem_next = r_remain - c_Q2;
    end else if (r_remain >= c_Q1 && r_inv_025 != '0) begin
      w_coin     = 3'b001;
      w_rem_next = r_remain - c_Q1;
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      r_state    <= c_ST_IDLE;
      r_gap_cnt  <= '0;
      r_remain   <= '0;
      r_inv_1    <= c_INV_1;
      r_inv_05   <= c_INV_05;
      r_inv_025  <= c_INV_025;
      r_coin_1   <= 1'b0;
      r_coin_05  <= 1'b0;
      r_coin_025 <= 1'b0;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_coin_1   <= 1'b0;
      r_coin_05  <= 1'b0;
      r_coin_025 <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.in_refill) begin
            r_inv_1   <= c_INV_1;
            r_inv_05  <= c_INV_05;
            r_inv_025 <= c_INV_025;
          end
          if (bus.in_start) begin
            r_short <= 1'b0;
            r_err   <= 1'b0;
            if (bus.in_amount[AMT_W-1]) begin
              r_err    <= 1'b1;
              r_remain <= '0;
              r_state  <= c_ST_DONE;
            end else if (bus.in_amount == '0) begin
              r_remain <= '0;
              r_state  <= c_ST_DONE;
            end else begin
              r_remain <= bus.in_amount[AMT_W-2:0];
              r_state  <= c_ST_PAY;
            end
          end
        end
        c_ST_PAY: begin
          if (w_coin == 3'b000) begin
            r_short <= 1'b1;
            r_state <= c_ST_DONE;
          end else begin
            {r_coin_1, r_coin_05, r_coin_025} <= w_coin;
            r_remain <= w_rem_next;
            if (w_coin[2]) r_inv_1   <= r_inv_1   - c_INV_DEC;
            if (w_coin[1]) r_inv_05  <= r_inv_05  - c_INV_DEC;
            if (w_coin[0]) r_inv_025 <= r_inv_025 - c_INV_DEC;
            if (w_rem_next == '0) begin
              r_state <= c_ST_DONE;
            end else if (GAP > 0) begin
              r_gap_cnt <= c_GAP_LOAD;
              r_state   <= c_ST_GAP;
            end
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt <= c_GAP_ONE) begin
            r_state <= c_ST_PAY;
          end else begin
            r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
          end
        end
        c_ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.out_busy     = (r_state != c_ST_IDLE);
  assign bus.out_coin_1   = r_coin_1;
  assign bus.out_coin_05  = r_coin_05;
  assign bus.out_coin_025 = r_coin_025;
  assign bus.out_done     = r_done;
  assign bus.out_short    = r_short;
  assign bus.out_err      = r_err;
  assign bus.out_remain   = r_remain;
  assign bus.out_inv_1    = r_inv_1;
  assign bus.out_inv_05   = r_inv_05;
  assign bus.out_inv_025  = r_inv_025;
  assign bus.out_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// tb_change_dispenser -- directed scoreboard bench over four dispenser configurations
// Rev 1.0
module tb_change_dispenser;

  logic              clk = 1'b0;
  logic              rst_all;
  logic              restart;
  logic              start;
  logic              refill;
  logic signed [15:0] amount;
  logic [1:0]        sel;
  int                checks   = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  state;
    logic        busy;
    logic        done;
    logic        shrt;
    logic        err;
    logic        c1;
    logic        c05;
    logic        c025;
    logic [14:0] rem;
    logic [7:0]  i1;
    logic [7:0]  i05;
    logic [7:0]  i025;
  } obs_t;

  typedef struct {
    logic [2:0] coin;
    int         rem;
  } exp_t;

  obs_t obs_v [4];
  obs_t obs;
  exp_t sb [$];

  assign obs = obs_v[sel];

  // 0: defaults, 1: GAP=2, 2: single $1 coin, 3: no quarters
  generate
    for (genvar k = 0; k < 4; k++) begin : g_dut
      change_dispenser_if #(.AMT_W(16), .INV_W(8)) u_if ();
      assign u_if.in_start  = start  && (int'(sel) == k);
      assign u_if.in_refill = refill && (int'(sel) == k);
      assign u_if.in_amount = amount;
      change_dispenser #(
        .AMT_W(16), .INV_W(8),
        .INV_1_INIT((k == 2) ? 1 : 20),
        .INV_05_INIT(20),
        .INV_025_INIT((k == 3) ? 0 : 40),
        .GAP((k == 1) ? 2 : 0)
      ) u_dut (
        .in_clka(clk),
        .in_restart(rst_all || (restart && (int'(sel) == k))),
        .bus(u_if)
      );
      assign obs_v[k] = {u_if.out_state, u_if.out_busy, u_if.out_done, u_if.out_short,
                         u_if.out_err, u_if.out_coin_1, u_if.out_coin_05, u_if.out_coin_025,
                         u_if.out_remain, u_if.out_inv_1, u_if.out_inv_05, u_if.out_inv_025};
    end
  endgenerate

  task automatic chk(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [2:0] coin, input int rem);
    exp_t e;
    e.coin = coin;
    e.rem  = rem;
    sb.push_back(e);
  endtask

  task automatic run_req(input logic [1:0] d, input int amt, input bit rf, input int hold,
                         input int gap, input int exp_done, input bit e_short, input bit e_err,
                         input int e_rem, input int e_i1, input int e_i05, input int e_i025);
    int   last     = -1;
    int   first    = -1;
    int   done_cyc = -1;
    exp_t e;
    @(negedge clk);
    sel    = d;
    amount = 16'(amt);
    refill = rf;
    start  = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      refill = 1'b0;
      if (c == 1) begin
        chk("busy_after_start", obs.busy, 1);
        chk("state_after_start", obs.state, (amt > 0) ? 1 : 3);
        chk("err_after_start", obs.err, (amt < 0) ? 1 : 0);
      end
      if (obs.c1 || obs.c05 || obs.c025) begin
        chk("coin_onehot", $countones({obs.c1, obs.c05, obs.c025}), 1);
        if (first < 0) begin
          first = c;
          chk("first_coin_cycle", c, 2);
        end
        if (last >= 0) chk("coin_spacing", c - last, gap + 1);
        last = c;
        chk("coin_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("coin_kind", {obs.c1, obs.c05, obs.c025}, e.coin);
          chk("remain_after_coin", obs.rem, e.rem);
        end
      end
      if (obs.done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    chk("busy_at_done", obs.busy, 0);
    chk("state_at_done", obs.state, 0);
    chk("short_at_done", obs.shrt, e_short);
    chk("err_at_done", obs.err, e_err);
    chk("remain_at_done", obs.rem, e_rem);
    chk("inv_1", obs.i1, e_i1);
    chk("inv_05", obs.i05, e_i05);
    chk("inv_025", obs.i025, e_i025);
    @(negedge clk);
    chk("done_one_cycle", obs.done, 0);
    chk("short_held", obs.shrt, e_short);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_all = 1'b1;
    restart = 1'b0;
    start   = 1'b0;
    refill  = 1'b0;
    amount  = '0;
    sel     = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", obs.state, 0);
    chk("rst_busy", obs.busy, 0);
    chk("rst_pulses", {obs.c1, obs.c05, obs.c025, obs.done}, 0);
    chk("rst_short_err", {obs.shrt, obs.err}, 0);
    chk("rst_remain", obs.rem, 0);
    chk("rst_inv_1", obs.i1, 20);
    chk("rst_inv_05", obs.i05, 20);
    chk("rst_inv_025", obs.i025, 40);
    sel = 2'd2;
    #1 chk("rst_inv_1_cfg", obs.i1, 1);
    sel = 2'd3;
    #1 chk("rst_inv_025_cfg", obs.i025, 0);
    rst_all = 1'b0;

    // Defaults, 7 quarters: $1, $0.50, $0.25 back to back
    push(3'b100, 3); push(3'b010, 1); push(3'b001, 0);
    run_req(2'd0, 7, 1'b0, 1, 0, 5, 1'b0, 1'b0, 0, 19, 19, 39);

    // One $1 coin stocked: fallback to halves after it runs out
    push(3'b100, 5); push(3'b010, 3); push(3'b010, 1); push(3'b001, 0);
    run_req(2'd2, 9, 1'b0, 1, 0, 6, 1'b0, 1'b0, 0, 0, 18, 39);

    // No quarters: shortfall with one quarter still owed
    push(3'b010, 1);
    run_req(2'd3, 3, 1'b0, 1, 0, 4, 1'b1, 1'b0, 1, 20, 19, 0);

    // Negative amount flags error, then a good request clears it
    run_req(2'd0, -3, 1'b0, 1, 0, 2, 1'b0, 1'b1, 0, 19, 19, 39);
    push(3'b100, 0);
    run_req(2'd0, 4, 1'b0, 1, 0, 3, 1'b0, 1'b0, 0, 18, 19, 39);

    // GAP=2 spacing with start held high during payout
    push(3'b100, 4); push(3'b100, 0);
    run_req(2'd1, 8, 1'b0, 3, 2, 6, 1'b0, 1'b0, 0, 18, 20, 40);

    // Restart while in the gap between coins
    @(negedge clk);
    sel    = 2'd1;
    amount = 16'sd8;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("gap_run_coin", obs.c1, 1);
    chk("gap_run_state", obs.state, 2);
    chk("gap_run_inv_1", obs.i1, 17);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_state", obs.state, 0);
    chk("restart_busy", obs.busy, 0);
    chk("restart_pulses", {obs.c1, obs.c05, obs.c025, obs.done}, 0);
    chk("restart_remain", obs.rem, 0);
    chk("restart_inv_1", obs.i1, 20);
    chk("restart_inv_05", obs.i05, 20);
    chk("restart_inv_025", obs.i025, 40);
    @(negedge clk);
    chk("restart_no_coin", {obs.c1, obs.c05, obs.c025}, 0);

    // Refill and start together: counts restored before paying
    push(3'b100, 3); push(3'b010, 1); push(3'b001, 0);
    run_req(2'd0, 7, 1'b1, 1, 0, 5, 1'b0, 1'b0, 0, 19, 19, 39);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Payout stage directly downstream of the vending controller. It accepts the signed change amount the controller produces at the end of a transaction and releases physical coins one pulse at a time ($1, $0.50, $0.25). It tracks per-denomination coin inventory, falls back to smaller coins when a larger tube is empty, and flags a shortfall when exact change cannot be paid.

## Interface
- AMT_W, 16, width of the signed change amount; LSB = $0.25
- INV_W, 8, width of each coin-inventory counter
- INV_1_INIT, 20, $1 coin count loaded at reset/refill
- INV_05_INIT, 20, $0.50 coin count loaded at reset/refill
- INV_025_INIT, 40, $0.25 coin count loaded at reset/refill
- GAP, 1, idle cycles between consecutive coin pulses (0 = back-to-back)

- in_clka  in  1  single clock, all logic on rising edge
- in_restart  in  1  synchronous active-high reset
- in_start  in  1  request payout of in_amount; sampled only in IDLE
- in_amount  in  AMT_W signed  change in quarters; captured when start accepted
- in_refill  in  1  reload all inventories to *_INIT; honoured only in IDLE
- out_busy  out  1  high whenever state != IDLE
- out_coin_1 / out_coin_05 / out_coin_025  out  1 each  one-cycle coin-release pulses; at most one high per cycle
- out_done  out  1  one-cycle pulse at end of every accepted request
- out_short  out  1  exact change not possible; held until next accepted start or reset
- out_err  out  1  negative amount requested; held until next accepted start or reset
- out_remain  out  AMT_W-1  quarters still owed
- out_inv_1 / out_inv_05 / out_inv_025  out  INV_W each  current inventories
- out_state  out  2  IDLE=0, PAY=1, GAP=2, DONE=3

## Operation
- Reset values: state IDLE, all pulses 0, out_busy 0, out_short 0, out_err 0, out_remain 0, inventories = *_INIT.
- IDLE, in_start=1: clear out_short/out_err.
  - amount < 0: out_err=1, remain=0, go DONE.
  - amount = 0: go DONE.
  - otherwise: remain = amount[AMT_W-2:0], go PAY.
- PAY: priority selection, one coin per visit:
  - remain>=4 and inv_1>0: coin_1, remain-=4, inv_1-=1.
  - else remain>=2 and inv_05>0: coin_05, remain-=2, inv_05-=1.
  - else remain>=1 and inv_025>0: coin_025, remain-=1, inv_025-=1.
  - else: out_short=1, remain held, go DONE.
  - After a coin: new remain=0 goes DONE; else GAP>0 goes GAP (counter=GAP); else stays PAY.
- GAP: decrement counter; at 1 return to PAY. No pulses.
- DONE: out_done=1 for exactly one cycle, go IDLE.
- in_start outside IDLE is ignored; it is not queued.
- in_refill and in_start both high in IDLE: both accepted. The refill applies at that edge, and payout uses the refilled counts.
- Inventories never underflow; a zero counter is never selected.
- in_restart mid-payout: immediate return to reset values. Any pulse in flight is dropped, and inventories reload to INIT.

## Timing
- Start sampled at edge N: out_busy=1 and out_state=PAY visible after N.
- First coin pulse is visible after edge N+1, for one cycle.
- With GAP=G, successive coin pulses are spaced G+1 cycles apart.
- Last coin registered at edge M: state DONE after M. After M+1, out_done=1, out_busy=0, state IDLE.
- Zero or negative amount: DONE after N, out_done after N+1, no coins.
- Shortfall detected at edge S: out_short visible after S, out_done after S+1.
- out_remain and inventories update on the same edge as the corresponding pulse.
- Earliest next start accepted is the edge after out_done.

## Test plan
- Reset defaults, GAP=0, amount=7: coin_1, coin_05, coin_025 on 3 consecutive cycles. Remain 3→1→0. Inventories 19/19/39. out_done one cycle after last coin.
- INV_1_INIT=1, amount=9: coin_1, coin_05, coin_05, coin_025. inv_1=0, inv_05=18. out_short=0.
- INV_025_INIT=0, amount=3: coin_05, then out_short=1, out_remain=1, out_done. No coin_025.
- amount=-3: out_err=1, out_done after 2 cycles, no coin pulses, inventories unchanged. Next start with amount=4 clears out_err.
- GAP=2, amount=8: two coin_1 pulses 3 cycles apart. in_start re-asserted mid-payout is ignored.
- in_restart asserted in GAP: next cycle is IDLE with pulses 0, remain 0, inventories = INIT. in_refill+in_start together in IDLE restores counts before paying.
